// File: rtl/seg_scan_ctrl.sv
// Purpose : multiplexed seven-segment scan controller with tear-free display update;
//           optional leading-zero blanking when SEG_LZB_EN is defined.
// Latency : a value accepted in frame N is shown from frame N+1; seg/dp/an are registered.
// Backpressure: wr_ready drops while a value is pending and rises the cycle after frame_done.
//
// Ports:
//   clk, rst (async, active-low)
//   wr_valid/wr_ready/wr_data/wr_dp : display value handshake (BCD nibble k = digit k)
//   seg[6:0] (a..g), dp, an[DIGITS-1:0] : registered, active-high digit drive
//   frame_done : one-cycle pulse in the final DRIVE cycle of the last digit
module seg_scan_ctrl #(
    parameter int DIGITS       = 4,
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [4*DIGITS-1:0]   wr_data,
    input  logic [DIGITS-1:0]     wr_dp,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int CMAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int IW   = $clog2(DIGITS);

    localparam logic [CW-1:0] P_LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] B_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] I_LAST = IW'(DIGITS - 1);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    logic [0:0]           state, state_nx;
    logic [CW-1:0]        cnt, cnt_nx;
    logic [IW-1:0]        idx, idx_nx;
    logic [4*DIGITS-1:0]  disp, disp_nx, pend;
    logic [DIGITS-1:0]    disp_dp, disp_dp_nx, pend_dp;
    logic                 pend_full;
    logic                 fd_nx;
    logic [DIGITS-1:0]    lz;
    logic [DIGITS-1:0]    an_nx;
    logic [6:0]           seg_nx;
    logic                 dp_nx;
    logic [3:0]           nib;
    logic                 dp_sel;
    logic                 lz_sel;

    // Gating with rst keeps ready low while reset is held.
    assign wr_ready = rst & ~pend_full;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Scan sequencing: BLANK for BLANK_CYCLES, then DRIVE for PRESCALE, then next digit.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        if (state == ST_BLANK) begin
            if (cnt == B_LAST) begin
                state_nx = ST_DRIVE;
                cnt_nx   = '0;
            end else begin
                cnt_nx = cnt + CW'(1);
            end
        end else begin
            if (cnt == P_LAST) begin
                state_nx = ST_BLANK;
                cnt_nx   = '0;
                idx_nx   = (idx == I_LAST) ? '0 : idx + IW'(1);
            end else begin
                cnt_nx = cnt + CW'(1);
            end
        end
        // frame_done is high during the last DRIVE cycle of the last digit, so
        // registering this condition from the next-state values aligns it.
        fd_nx = (state_nx == ST_DRIVE) && (idx_nx == I_LAST) && (cnt_nx == P_LAST);
    end

    // The pending value swaps in on the edge that ends the frame; the next cycle
    // is BLANK for digit 0, so no digit ever shows a mix of old and new data.
    always_comb begin
        disp_nx    = disp;
        disp_dp_nx = disp_dp;
        if (frame_done && pend_full) begin
            disp_nx    = pend;
            disp_dp_nx = pend_dp;
        end
    end

`ifdef SEG_LZB_EN
    // lz[k] is set when nibble k and every higher nibble are zero; digit 0 never blanks.
    always_comb begin
        logic lead;
        lead = 1'b1;
        lz   = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            lead  = lead & (disp_nx[4*k +: 4] == 4'd0);
            lz[k] = lead;
        end
    end
`else
    assign lz = '0;
`endif

    // Outputs are computed from next-state values and registered together, so
    // an, seg and dp always change in the same cycle and refer to the same digit.
    always_comb begin
        an_nx  = '0;
        seg_nx = '0;
        dp_nx  = 1'b0;
        nib    = 4'd0;
        dp_sel = 1'b0;
        lz_sel = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_nx == IW'(k)) begin
                nib    = disp_nx[4*k +: 4];
                dp_sel = disp_dp_nx[k];
                lz_sel = lz[k];
            end
        end
        if (state_nx == ST_DRIVE) begin
            for (int k = 0; k < DIGITS; k++) begin
                an_nx[k] = (idx_nx == IW'(k));
            end
            seg_nx = lz_sel ? 7'b0000000 : decode(nib);
            dp_nx  = dp_sel;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_BLANK;
            cnt        <= '0;
            idx        <= '0;
            disp       <= '0;
            disp_dp    <= '0;
            pend       <= '0;
            pend_dp    <= '0;
            pend_full  <= 1'b0;
            seg        <= '0;
            dp         <= 1'b0;
            an         <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            idx        <= idx_nx;
            disp       <= disp_nx;
            disp_dp    <= disp_dp_nx;
            seg        <= seg_nx;
            dp         <= dp_nx;
            an         <= an_nx;
            frame_done <= fd_nx;
            if (frame_done && pend_full) begin
                pend_full <= 1'b0;
            end
            // Acceptance and the frame-boundary clear never coincide: ready is low while full.
            if (wr_valid && wr_ready) begin
                pend      <= wr_data;
                pend_dp   <= wr_dp;
                pend_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Purpose : self-checking bench for seg_scan_ctrl (DIGITS=4, PRESCALE=4, BLANK_CYCLES=1).
// Latency : reference model predicts every output each cycle from the cycle index since reset.
// Backpressure: writes are held valid until the DUT shows ready, with a bounded wait.
module tb_seg_scan_ctrl;

    localparam int DIGITS = 4;
    localparam int PRESCALE = 4;
    localparam int BLANK_CYCLES = 1;
    localparam int SLOT = PRESCALE + BLANK_CYCLES;
    localparam int FRAME = DIGITS * SLOT;

    logic        clk;
    logic        rst;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_data;
    logic [3:0]  wr_dp;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    seg_scan_ctrl #(
        .DIGITS(DIGITS),
        .PRESCALE(PRESCALE),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_data(wr_data),
        .wr_dp(wr_dp),
        .seg(seg),
        .dp(dp),
        .an(an),
        .frame_done(frame_done)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [6:0] seg_tbl [0:9] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                  7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                  7'b1111111, 7'b1111011};

    // Reference model: cycle index since reset release, shown value, pending value.
    int          c;
    logic [15:0] m_disp, m_pend;
    logic [3:0]  m_ddp, m_pdp;
    bit          m_pfull;

    function automatic logic [6:0] exp_seg(input logic [15:0] v, input int k);
        int n;
        n = int'((v >> (4 * k)) & 16'hF);
`ifdef SEG_LZB_EN
        if (k > 0 && (v >> (4 * k)) == 16'h0) return 7'b0000000;
`endif
        if (n > 9) return 7'b0000000;
        return seg_tbl[n];
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            c = 0;
            m_disp = '0;
            m_ddp = '0;
            m_pend = '0;
            m_pdp = '0;
            m_pfull = 1'b0;
        end else begin
            bit acc;
            acc = wr_valid && !m_pfull;
            if ((c % FRAME) == FRAME - 1 && m_pfull) begin
                m_disp = m_pend;
                m_ddp = m_pdp;
                m_pfull = 1'b0;
            end
            if (acc) begin
                m_pend = wr_data;
                m_pdp = wr_dp;
                m_pfull = 1'b1;
            end
            c++;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("an_rst", 32'(an), 0);
            chk("seg_rst", 32'(seg), 0);
            chk("dp_rst", 32'(dp), 0);
            chk("fd_rst", 32'(frame_done), 0);
            chk("rdy_rst", 32'(wr_ready), 0);
        end else begin
            int  s, k;
            bit  drv;
            s = c % FRAME;
            k = s / SLOT;
            drv = (s % SLOT) >= BLANK_CYCLES;
            chk("an", 32'(an), drv ? (32'd1 << k) : 32'd0);
            chk("seg", 32'(seg), drv ? 32'(exp_seg(m_disp, k)) : 32'd0);
            chk("dp", 32'(dp), drv ? 32'(m_ddp[k]) : 32'd0);
            chk("frame_done", 32'(frame_done), 32'(s == FRAME - 1));
            chk("wr_ready", 32'(wr_ready), 32'(!m_pfull));
        end
    end

    // Called at a negedge; returns at a negedge with wr_valid still high.
    task automatic wr(input logic [15:0] d, input logic [3:0] p);
        bit done;
        done = 1'b0;
        wr_data = d;
        wr_dp = p;
        wr_valid = 1'b1;
        for (int n = 0; n < 3 * FRAME && !done; n++) begin
            if (wr_ready) begin
                done = 1'b1;
                @(posedge clk);
            end
            @(negedge clk);
        end
        if (!done) chk("wr_timeout", 0, 1);
    endtask

    task automatic wait_slot(input int s);
        bit hit;
        hit = 1'b0;
        for (int n = 0; n < 2 * FRAME && !hit; n++) begin
            if ((c % FRAME) == s) hit = 1'b1;
            else @(negedge clk);
        end
        if (!hit) chk("slot_timeout", 0, 1);
    endtask

    initial begin
        rst = 1'b0;
        wr_valid = 1'b0;
        wr_data = '0;
        wr_dp = '0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;

        // Idle frames showing 0000.
        repeat (45) @(negedge clk);

        // Mid-frame write of 1234 with dp on digit 2.
        wait_slot(7);
        wr(16'h1234, 4'b0100);
        wr_valid = 1'b0;
        repeat (45) @(negedge clk);

        // Back-to-back: second value stalls until the frame boundary.
        wr(16'h5678, 4'b0000);
        wr(16'h9999, 4'b0001);
        wr_valid = 1'b0;
        repeat (65) @(negedge clk);

        // Non-BCD nibble and leading zeros.
        wr(16'h00A7, 4'b0000);
        wr_valid = 1'b0;
        repeat (45) @(negedge clk);

        // Randomized traffic.
        for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(0, 30)) @(negedge clk);
            wr(16'($urandom), 4'($urandom));
            if ($urandom_range(0, 1) == 1) wr(16'($urandom), 4'($urandom));
            wr_valid = 1'b0;
        end
        repeat (45) @(negedge clk);

        // Reset during DRIVE of digit 2 with a value pending.
        wait_slot(1);
        wr(16'h4321, 4'b1111);
        wr_valid = 1'b0;
        wait_slot(2 * SLOT + 2);
        chk("pend_set_rdy", 32'(wr_ready), 0);
        #2 rst = 1'b0;
        #1;
        chk("async_an", 32'(an), 0);
        chk("async_seg", 32'(seg), 0);
        chk("async_dp", 32'(dp), 0);
        chk("async_fd", 32'(frame_done), 0);
        chk("async_rdy", 32'(wr_ready), 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        repeat (45) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter DIGITS, default 4: number of multiplexed seven-segment digits; legal range 2..8.
REQ-002 Parameter PRESCALE, default 1000: clk cycles each digit is driven (DRIVE phase); legal minimum 1.
REQ-003 Parameter BLANK_CYCLES, default 2: clk cycles of anti-ghost dead time before each digit; legal minimum 1.
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 wr_valid  input  1  new display value offered.
REQ-007 wr_ready  output  1  controller can accept a value.
REQ-008 wr_data  input  4*DIGITS  BCD nibbles; nibble k (bits 4k+3:4k) is digit k; digit 0 is least significant.
REQ-009 wr_dp  input  DIGITS  decimal-point request, bit k for digit k.
REQ-010 seg  output  7  segments a..g on seg[6]..seg[0]; active-high.
REQ-011 dp  output  1  decimal point of the driven digit; active-high.
REQ-012 an  output  DIGITS  digit enable, one-hot or all-zero; active-high.
REQ-013 frame_done  output  1  single-cycle pulse when a full scan of all digits completes.

Function
REQ-014 The FSM SHALL have two states: BLANK (an=0, seg=0, dp=0) and DRIVE (an[idx]=1, seg/dp from digit idx).
REQ-015 BLANK SHALL last exactly BLANK_CYCLES cycles, then go to DRIVE; DRIVE SHALL last exactly PRESCALE cycles, then go to BLANK with idx advanced.
REQ-016 idx SHALL count 0,1,...,DIGITS-1 and wrap to 0; frame_done SHALL pulse for one cycle on the DRIVE->BLANK transition that leaves idx=DIGITS-1.
REQ-017 seg, dp and an SHALL be registered and change in the same cycle; no cycle SHALL show segment data for one digit with another digit's enable.
REQ-018 A transfer SHALL occur when wr_valid and wr_ready are both high at a rising edge; wr_data/wr_dp are captured into a pending register and a pending-full flag is set.
REQ-019 wr_ready SHALL equal NOT pending-full; wr_ready is not combinationally dependent on wr_valid.
REQ-020 On the frame_done cycle, if pending-full is set, pending SHALL be copied into the display register and pending-full cleared; the new value is shown from the next frame onward (tear-free update).
REQ-021 A second value offered while pending-full is set SHALL stall (wr_ready=0) until the next frame boundary; wr_ready returns high the cycle after frame_done.
REQ-022 Decode (a..g): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011; nibbles 10..15 SHALL decode to 0000000 (blank), dp still honoured.
REQ-023 Internal counters SHALL be sized to hold max(PRESCALE, BLANK_CYCLES)-1 and DIGITS-1 without overflow.

Reset
REQ-024 On rst low: state=BLANK, idx=0, phase counter=0, display register=all zero nibbles and dp=0, pending-full=0.
REQ-025 During reset: seg=0, dp=0, an=0, frame_done=0, wr_ready=0; wr_ready SHALL rise the first cycle after rst deasserts.
REQ-026 Reset asserted mid-frame or with pending-full set SHALL discard the pending value and restart from BLANK, idx=0.

Configuration
REQ-027 Macro SEG_LZB_EN (leading-zero blanking): when defined, any digit k>0 whose nibble and all higher nibbles are 0 SHALL be driven with seg=0 (dp still honoured); digit 0 is never blanked.
REQ-028 Without SEG_LZB_EN, every digit SHALL decode its nibble per REQ-022 regardless of leading zeros.

Verification (bench: DIGITS=4, PRESCALE=4, BLANK_CYCLES=1)
REQ-029 Release reset, no writes -> an sequence 0000,0001x4,0000,0010x4,0000,0100x4,0000,1000x4; frame_done pulse every 20 cycles; seg=1111110 in DRIVE (macro off).
REQ-030 Write wr_data=16'h1234, wr_dp=4'b0100 mid-frame -> wr_ready low until cycle after frame_done; next frame digit0=0110011, digit1=1111001, digit2=1101101 with dp=1, digit3=0110000.
REQ-031 Hold wr_valid with 16'h5678 then 16'h9999 back-to-back -> second accepted only after first frame boundary; 5678 displayed one frame, then 9999.
REQ-032 Write 16'h00A7 -> digit1 nibble A shows 0000000; digit0 shows 1110000; with SEG_LZB_EN digits 3,2 blank, without it they show 1111110.
REQ-033 Assert rst during DRIVE of digit 2 with pending-full set -> outputs zero immediately (asynchronous); after release, display shows 0000 (macro off) and wr_ready=1.
